// File: rtl/char_ram_write_ctrl_pkg.sv
// rtl/char_ram_write_ctrl_pkg.sv - shared char display defaults, FSM states and address packing
package char_ram_write_ctrl_pkg;

  localparam int          DEF_LINE_CHAR_NUM = 56;
  localparam int          DEF_LINE_NUM      = 33;
  localparam logic [7:0]  DEF_FILL_CHAR     = 8'h20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic logic [13:0] pack_addr(input logic [6:0] line, input logic [6:0] column);
    return {line, column};
  endfunction

endpackage

// File: rtl/char_rr_arb2.sv
// rtl/char_rr_arb2.sv - two-way round-robin arbiter; pointer moves only when a grant is consumed
module char_rr_arb2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_advance,
  output logic o_grant0,
  output logic o_grant1
);

  logic r_prefer1;

  assign o_grant0 = i_valid0 & (~i_valid1 | ~r_prefer1);
  assign o_grant1 = i_valid1 & (~i_valid0 |  r_prefer1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prefer1 <= 1'b0;
    end else if (i_advance) begin
      r_prefer1 <= o_grant0;
    end
  end

endmodule

// File: rtl/char_ram_write_ctrl.sv
// rtl/char_ram_write_ctrl.sv - char RAM write port: round-robin requesters plus full-screen clear sweep
module char_ram_write_ctrl
  import char_ram_write_ctrl_pkg::*;
#(
  parameter int         LINE_CHAR_NUM = DEF_LINE_CHAR_NUM,
  parameter int         LINE_NUM      = DEF_LINE_NUM,
  parameter logic [7:0] FILL_CHAR     = DEF_FILL_CHAR
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        wr_allow,
  input  logic        clear_req,
  output logic        clear_busy,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [6:0]  req0_line,
  input  logic [6:0]  req0_column,
  input  logic [7:0]  req0_char,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [6:0]  req1_line,
  input  logic [6:0]  req1_column,
  input  logic [7:0]  req1_char,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        err_range
);

  localparam logic [6:0] LAST_COL  = 7'(LINE_CHAR_NUM - 1);
  localparam logic [6:0] LAST_LINE = 7'(LINE_NUM - 1);

  state_t      r_state;
  logic [6:0]  r_line;
  logic [6:0]  r_col;
  logic        r_wr_en;
  logic [13:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_busy;
  logic        r_err;

  logic        w_grant0;
  logic        w_grant1;
  logic        w_slot_ok;
  logic        w_accept;
  logic [6:0]  w_sel_line;
  logic [6:0]  w_sel_col;
  logic [7:0]  w_sel_char;
  logic        w_in_range;

  // A pending clear request steals the slot from both requesters.
  assign w_slot_ok  = (r_state == ST_IDLE) & ~clear_req & wr_allow;
  assign req0_ready = w_slot_ok & w_grant0;
  assign req1_ready = w_slot_ok & w_grant1;
  assign w_accept   = req0_ready | req1_ready;

  assign w_sel_line = req1_ready ? req1_line   : req0_line;
  assign w_sel_col  = req1_ready ? req1_column : req0_column;
  assign w_sel_char = req1_ready ? req1_char   : req0_char;
  assign w_in_range = (w_sel_line < 7'(LINE_NUM)) & (w_sel_col < 7'(LINE_CHAR_NUM));

  char_rr_arb2 u_arb (
    .i_clk     (pixel_clock),
    .i_rst_n   (reset),
    .i_valid0  (req0_valid),
    .i_valid1  (req1_valid),
    .i_advance (w_accept),
    .o_grant0  (w_grant0),
    .o_grant1  (w_grant1)
  );

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_line    <= 7'd0;
      r_col     <= 7'd0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 14'd0;
      r_wr_data <= 8'd0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clear_req) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_line  <= 7'd0;
            r_col   <= 7'd0;
          end else if (w_accept) begin
            if (w_in_range) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= pack_addr(w_sel_line, w_sel_col);
              r_wr_data <= w_sel_char;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          // Without a write slot the sweep simply holds its position.
          if (wr_allow) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= pack_addr(r_line, r_col);
            r_wr_data <= FILL_CHAR;
            if (r_col == LAST_COL) begin
              r_col <= 7'd0;
              if (r_line == LAST_LINE) begin
                r_line  <= 7'd0;
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_line <= r_line + 7'd1;
              end
            end else begin
              r_col <= r_col + 7'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign clear_busy = r_busy;
  assign err_range  = r_err;

endmodule
